// File: rtl/bof_run_tracker.sv
// bof_run_tracker: watches the issue-stage operand/operator stream for runs of contiguous,
// non-stack stores (heap-overflow shaped writes). A run closes when broken by a
// non-contiguous store or after DATE_MAX valid non-store instructions. Runs larger than
// WRITE_THRESH bytes are committed into a small round-robin range table. A valid load that
// lands in a committed range, or in the run being tracked, sets a sticky hit flag. The next
// qualifying JALR then raises a one-cycle crash request.
//
// Ports:
//   clk_i, rst_ni      clock, synchronous active-low reset
//   clr_i              software clear, same effect as reset
//   en_crash_i         enables crash_o generation
//   valid_i            instruction present; all other inputs ignored when low
//   is_store_i         SW/SH/SB, store_size_i = bytes stored (1/2/4, else treated as non-store)
//   is_load_i          LW/LH/LB
//   is_jalr_i          JALR
//   rs1_i              base register index (x2/sp and x8/fp stores are ignored)
//   vaddr_i            effective address
//   active_o           a run is being tracked
//   range_wr_o         one-cycle commit pulse with range_start_o/range_end_o (inclusive)
//   load_hit_o         sticky: last valid load hit a range
//   crash_o            one-cycle crash request
module bof_run_tracker #(
    parameter int unsigned VLEN         = 32,
    parameter int unsigned WRITE_THRESH = 32,
    parameter int unsigned DATE_MAX     = 10,
    parameter int unsigned N_RANGES     = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clr_i,
    input  logic            en_crash_i,
    input  logic            valid_i,
    input  logic            is_store_i,
    input  logic [2:0]      store_size_i,
    input  logic            is_load_i,
    input  logic            is_jalr_i,
    input  logic [4:0]      rs1_i,
    input  logic [VLEN-1:0] vaddr_i,
    output logic            active_o,
    output logic            range_wr_o,
    output logic [VLEN-1:0] range_start_o,
    output logic [VLEN-1:0] range_end_o,
    output logic            load_hit_o,
    output logic            crash_o
);

    localparam int unsigned PtrW  = (N_RANGES > 1) ? $clog2(N_RANGES) : 1;
    localparam int unsigned DateW = $clog2(DATE_MAX + 1);

    typedef enum logic [0:0] {
        StIdle,
        StTrack
    } state_e;

    state_e                 state_q, state_d;
    logic [VLEN-1:0]        start_q, start_d;
    logic [VLEN-1:0]        next_q, next_d;
    logic [15:0]            count_q, count_d;
    logic [DateW-1:0]       date_q, date_d;
    logic [PtrW-1:0]        ptr_q, ptr_d;
    logic [N_RANGES-1:0]    tbl_valid_q, tbl_valid_d;
    logic [VLEN-1:0]        tbl_start_q [N_RANGES];
    logic [VLEN-1:0]        tbl_start_d [N_RANGES];
    logic [VLEN-1:0]        tbl_end_q   [N_RANGES];
    logic [VLEN-1:0]        tbl_end_d   [N_RANGES];
    logic                   range_wr_q, range_wr_d;
    logic [VLEN-1:0]        range_start_q, range_start_d;
    logic [VLEN-1:0]        range_end_q, range_end_d;
    logic                   load_hit_q, load_hit_d;
    logic                   crash_q, crash_d;

    logic                   legal_size;
    logic                   stack_base;
    logic                   tracked_store;
    logic                   non_store;
    logic                   contiguous;
    logic                   close_run;
    logic                   hit;
    logic [VLEN-1:0]        size_ext;
    logic [16:0]            count_sum;

    always_comb begin
        legal_size    = (store_size_i == 3'd1) || (store_size_i == 3'd2) ||
                        (store_size_i == 3'd4);
        stack_base    = (rs1_i == 5'd2) || (rs1_i == 5'd8);
        tracked_store = valid_i && is_store_i && legal_size && !stack_base;
        // Illegal-size stores count as ordinary instructions; stack stores are invisible.
        non_store     = valid_i && !(is_store_i && legal_size);
        size_ext      = VLEN'(store_size_i);
        contiguous    = (state_q == StTrack) && (vaddr_i == next_q);
        count_sum     = {1'b0, count_q} + 17'(store_size_i);

        // Hit check sees only pre-update state of this cycle.
        hit = 1'b0;
        for (int i = 0; i < int'(N_RANGES); i++) begin
            if (tbl_valid_q[i] && (vaddr_i >= tbl_start_q[i]) && (vaddr_i <= tbl_end_q[i])) begin
                hit = 1'b1;
            end
        end
        if ((state_q == StTrack) && (vaddr_i >= start_q) && (vaddr_i < next_q)) begin
            hit = 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        start_d       = start_q;
        next_d        = next_q;
        count_d       = count_q;
        date_d        = date_q;
        ptr_d         = ptr_q;
        tbl_valid_d   = tbl_valid_q;
        tbl_start_d   = tbl_start_q;
        tbl_end_d     = tbl_end_q;
        range_wr_d    = 1'b0;
        range_start_d = range_start_q;
        range_end_d   = range_end_q;
        load_hit_d    = load_hit_q;
        crash_d       = 1'b0;
        close_run     = 1'b0;

        if (tracked_store) begin
            if (contiguous) begin
                next_d  = next_q + size_ext;
                count_d = count_sum[16] ? 16'hFFFF : count_sum[15:0];
                date_d  = DateW'(DATE_MAX);
            end else begin
                // A break closes the old run and starts a new one from this store.
                close_run = (state_q == StTrack);
                state_d   = StTrack;
                start_d   = vaddr_i;
                next_d    = vaddr_i + size_ext;
                count_d   = {13'd0, store_size_i};
                date_d    = DateW'(DATE_MAX);
            end
        end else if (non_store && (state_q == StTrack)) begin
            if (date_q == '0) begin
                close_run = 1'b1;
                state_d   = StIdle;
            end else begin
                date_d = date_q - DateW'(1);
            end
        end

        if (close_run && (32'(count_q) > WRITE_THRESH)) begin
            tbl_valid_d[ptr_q] = 1'b1;
            tbl_start_d[ptr_q] = start_q;
            tbl_end_d[ptr_q]   = next_q - VLEN'(1);
            ptr_d              = ptr_q + PtrW'(1);
            range_wr_d         = 1'b1;
            range_start_d      = start_q;
            range_end_d        = next_q - VLEN'(1);
        end

        if (valid_i && is_load_i) begin
            load_hit_d = hit;
        end else if (valid_i && is_jalr_i && load_hit_q && en_crash_i) begin
            crash_d    = 1'b1;
            load_hit_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clr_i) begin
            state_q       <= StIdle;
            start_q       <= '0;
            next_q        <= '0;
            count_q       <= '0;
            date_q        <= '0;
            ptr_q         <= '0;
            tbl_valid_q   <= '0;
            for (int i = 0; i < int'(N_RANGES); i++) begin
                tbl_start_q[i] <= '0;
                tbl_end_q[i]   <= '0;
            end
            range_wr_q    <= 1'b0;
            range_start_q <= '0;
            range_end_q   <= '0;
            load_hit_q    <= 1'b0;
            crash_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            start_q       <= start_d;
            next_q        <= next_d;
            count_q       <= count_d;
            date_q        <= date_d;
            ptr_q         <= ptr_d;
            tbl_valid_q   <= tbl_valid_d;
            tbl_start_q   <= tbl_start_d;
            tbl_end_q     <= tbl_end_d;
            range_wr_q    <= range_wr_d;
            range_start_q <= range_start_d;
            range_end_q   <= range_end_d;
            load_hit_q    <= load_hit_d;
            crash_q       <= crash_d;
        end
    end

    assign active_o      = (state_q == StTrack);
    assign range_wr_o    = range_wr_q;
    assign range_start_o = range_start_q;
    assign range_end_o   = range_end_q;
    assign load_hit_o    = load_hit_q;
    assign crash_o       = crash_q;

endmodule

// File: tb/tb_bof_run_tracker.sv
// Bench for bof_run_tracker: directed scenarios followed by a randomized instruction stream,
// all compared every cycle against a behavioural model (runs as address intervals, committed
// ranges as a FIFO of the most recent four).
module tb_bof_run_tracker;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        clr_i;
    logic        en_crash_i;
    logic        valid_i;
    logic        is_store_i;
    logic [2:0]  store_size_i;
    logic        is_load_i;
    logic        is_jalr_i;
    logic [4:0]  rs1_i;
    logic [31:0] vaddr_i;
    logic        active_o;
    logic        range_wr_o;
    logic [31:0] range_start_o;
    logic [31:0] range_end_o;
    logic        load_hit_o;
    logic        crash_o;

    always #5 clk_i = ~clk_i;

    bof_run_tracker #(
        .VLEN         (32),
        .WRITE_THRESH (32),
        .DATE_MAX     (10),
        .N_RANGES     (4)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .clr_i         (clr_i),
        .en_crash_i    (en_crash_i),
        .valid_i       (valid_i),
        .is_store_i    (is_store_i),
        .store_size_i  (store_size_i),
        .is_load_i     (is_load_i),
        .is_jalr_i     (is_jalr_i),
        .rs1_i         (rs1_i),
        .vaddr_i       (vaddr_i),
        .active_o      (active_o),
        .range_wr_o    (range_wr_o),
        .range_start_o (range_start_o),
        .range_end_o   (range_end_o),
        .load_hit_o    (load_hit_o),
        .crash_o       (crash_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
    } range_t;

    range_t      m_ranges[$];
    bit          m_active = 1'b0;
    logic [31:0] m_start  = '0;
    logic [31:0] m_next   = '0;
    int          m_count  = 0;
    int          m_date   = 0;
    bit          exp_wr    = 1'b0;
    logic [31:0] exp_rs    = '0;
    logic [31:0] exp_re    = '0;
    bit          exp_hit   = 1'b0;
    bit          exp_crash = 1'b0;

    function automatic void model_close();
        range_t r;
        range_t dropped;
        if (m_count > 32) begin
            r.lo = m_start;
            r.hi = m_next - 32'd1;
            m_ranges.push_back(r);
            if (m_ranges.size() > 4) dropped = m_ranges.pop_front();
            exp_wr = 1'b1;
            exp_rs = r.lo;
            exp_re = r.hi;
        end
    endfunction

    function automatic void model_step();
        bit legal;
        bit tracked;
        bit nonstore;
        bit hit;
        if (!rst_ni || clr_i) begin
            m_active  = 1'b0;
            m_ranges.delete();
            m_count   = 0;
            m_date    = 0;
            exp_wr    = 1'b0;
            exp_hit   = 1'b0;
            exp_crash = 1'b0;
        end else begin
            legal    = store_size_i inside {3'd1, 3'd2, 3'd4};
            tracked  = valid_i && is_store_i && legal && !(rs1_i inside {5'd2, 5'd8});
            nonstore = valid_i && !(is_store_i && legal);
            hit = 1'b0;
            foreach (m_ranges[i]) begin
                if (vaddr_i >= m_ranges[i].lo && vaddr_i <= m_ranges[i].hi) hit = 1'b1;
            end
            if (m_active && vaddr_i >= m_start && vaddr_i < m_next) hit = 1'b1;
            exp_wr    = 1'b0;
            exp_crash = 1'b0;
            if (tracked) begin
                if (m_active && vaddr_i == m_next) begin
                    m_next  = m_next + 32'(store_size_i);
                    m_count = (m_count + int'(store_size_i) > 65535) ? 65535
                              : m_count + int'(store_size_i);
                    m_date  = 10;
                end else begin
                    if (m_active) model_close();
                    m_active = 1'b1;
                    m_start  = vaddr_i;
                    m_next   = vaddr_i + 32'(store_size_i);
                    m_count  = int'(store_size_i);
                    m_date   = 10;
                end
            end else if (nonstore && m_active) begin
                if (m_date == 0) begin
                    model_close();
                    m_active = 1'b0;
                end else begin
                    m_date--;
                end
            end
            if (valid_i && is_load_i) begin
                exp_hit = hit;
            end else if (valid_i && is_jalr_i && exp_hit && en_crash_i) begin
                exp_crash = 1'b1;
                exp_hit   = 1'b0;
            end
        end
    endfunction

    // ---------------- stimulus ----------------
    task automatic op(input bit v, input bit st, input logic [2:0] sz, input bit ld,
                      input bit jr, input logic [4:0] rs1, input logic [31:0] a);
        valid_i      = v;
        is_store_i   = st;
        store_size_i = sz;
        is_load_i    = ld;
        is_jalr_i    = jr;
        rs1_i        = rs1;
        vaddr_i      = a;
        @(posedge clk_i);
        model_step();
        #1;
        check_eq("active", 32'(active_o), 32'(m_active));
        check_eq("range_wr", 32'(range_wr_o), 32'(exp_wr));
        if (exp_wr) begin
            check_eq("range_start", range_start_o, exp_rs);
            check_eq("range_end", range_end_o, exp_re);
        end
        check_eq("load_hit", 32'(load_hit_o), 32'(exp_hit));
        check_eq("crash", 32'(crash_o), 32'(exp_crash));
        @(negedge clk_i);
    endtask

    task automatic sw(input logic [31:0] a, input logic [4:0] rs1 = 5'd10);
        op(1'b1, 1'b1, 3'd4, 1'b0, 1'b0, rs1, a);
    endtask
    task automatic alu();
        op(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 5'd1, 32'h0);
    endtask
    task automatic lw(input logic [31:0] a);
        op(1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 5'd1, a);
    endtask
    task automatic jalr();
        op(1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 5'd1, 32'h0);
    endtask
    task automatic idle();
        op(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 5'd0, 32'h0);
    endtask
    task automatic clear();
        clr_i = 1'b1;
        idle();
        clr_i = 1'b0;
    endtask

    // Ten word stores from base then a timeout; commits [base, base+0x27].
    task automatic commit_run(input logic [31:0] base);
        for (int i = 0; i < 10; i++) sw(base + 32'(4 * i));
        for (int i = 0; i < 11; i++) alu();
    endtask

    initial begin
        logic [2:0]  sz;
        logic [31:0] a;
        logic [4:0]  rs1;
        int          k;
        bit          v;

        rst_ni = 1'b0; clr_i = 1'b0; en_crash_i = 1'b0;
        valid_i = 1'b0; is_store_i = 1'b0; store_size_i = '0; is_load_i = 1'b0;
        is_jalr_i = 1'b0; rs1_i = '0; vaddr_i = '0;
        @(negedge clk_i);
        idle();
        idle();
        check_eq("rst_active", 32'(active_o), 32'd0);
        check_eq("rst_range_wr", 32'(range_wr_o), 32'd0);
        check_eq("rst_load_hit", 32'(load_hit_o), 32'd0);
        rst_ni = 1'b1;
        idle();

        // Commit on timeout.
        for (int i = 0; i < 10; i++) sw(32'h1000 + 32'(4 * i));
        for (int i = 0; i < 10; i++) alu();
        check_eq("tp1_no_early_wr", 32'(range_wr_o), 32'd0);
        alu();
        check_eq("tp1_wr", 32'(range_wr_o), 32'd1);
        check_eq("tp1_start", range_start_o, 32'h1000);
        check_eq("tp1_end", range_end_o, 32'h1027);
        check_eq("tp1_active", 32'(active_o), 32'd0);

        // Exactly threshold bytes is discarded; restart at the breaking store.
        for (int i = 0; i < 8; i++) sw(32'h2000 + 32'(4 * i));
        op(1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 5'd10, 32'h3000);
        check_eq("tp2_no_wr", 32'(range_wr_o), 32'd0);
        check_eq("tp2_active", 32'(active_o), 32'd1);
        lw(32'h3000);
        check_eq("tp2_active_hit", 32'(load_hit_o), 32'd1);
        lw(32'h2004);
        check_eq("tp2_discarded_miss", 32'(load_hit_o), 32'd0);
        for (int i = 0; i < 11; i++) alu();

        // Load hit then crash on JALR.
        en_crash_i = 1'b1;
        lw(32'h1010);
        check_eq("tp3_hit", 32'(load_hit_o), 32'd1);
        jalr();
        check_eq("tp3_crash", 32'(crash_o), 32'd1);
        check_eq("tp3_hit_clr", 32'(load_hit_o), 32'd0);
        alu();
        check_eq("tp3_crash_pulse", 32'(crash_o), 32'd0);

        // Crash disabled keeps the flag.
        en_crash_i = 1'b0;
        lw(32'h1010);
        jalr();
        check_eq("tp4_no_crash", 32'(crash_o), 32'd0);
        check_eq("tp4_hit_kept", 32'(load_hit_o), 32'd1);
        lw(32'h5000);
        check_eq("tp4_hit_cleared", 32'(load_hit_o), 32'd0);

        // Round-robin replacement.
        clear();
        for (int r = 1; r <= 5; r++) commit_run(32'(r) << 12);
        lw(32'h1004);
        check_eq("tp5_evicted", 32'(load_hit_o), 32'd0);
        lw(32'h5004);
        check_eq("tp5_newest", 32'(load_hit_o), 32'd1);

        // Stack stores, clear and reset mid-run.
        clear();
        sw(32'h6000);
        sw(32'h6004);
        sw(32'h6100, 5'd2);
        sw(32'h6008);
        sw(32'h9000, 5'd8);
        sw(32'h600C);
        clr_i = 1'b1;
        sw(32'h6010);
        clr_i = 1'b0;
        check_eq("tp6_clr_active", 32'(active_o), 32'd0);
        alu();
        check_eq("tp6_clr_no_wr", 32'(range_wr_o), 32'd0);
        for (int i = 0; i < 9; i++) sw(32'h7000 + 32'(4 * i));
        rst_ni = 1'b0;
        sw(32'h7024);
        rst_ni = 1'b1;
        check_eq("tp6_rst_active", 32'(active_o), 32'd0);
        for (int i = 0; i < 12; i++) alu();

        // Run across the top of the address space.
        clear();
        commit_run(32'hFFFF_FFE0);
        check_eq("wrap_end", range_end_o, 32'h0000_0007);
        lw(32'h0000_0004);
        check_eq("wrap_no_hit", 32'(load_hit_o), 32'd0);

        // Random stream.
        for (int n = 0; n < 4000; n++) begin
            k          = $urandom_range(0, 199);
            clr_i      = (k == 0);
            rst_ni     = (k != 1);
            en_crash_i = $urandom_range(0, 1) != 0;
            v          = $urandom_range(0, 9) != 0;
            k          = $urandom_range(0, 99);
            if (k < 50) begin
                case ($urandom_range(0, 5))
                    0: sz = 3'd1;
                    1: sz = 3'd2;
                    2: sz = 3'(($urandom_range(0, 1) != 0) ? 3 : 0);
                    default: sz = 3'd4;
                endcase
                if (m_active && $urandom_range(0, 9) != 0) a = m_next;
                else a = (32'($urandom_range(1, 8)) << 12) + 32'($urandom_range(0, 15));
                if ($urandom_range(0, 19) == 0) rs1 = ($urandom_range(0, 1) != 0) ? 5'd2 : 5'd8;
                else rs1 = 5'd10;
                op(v, 1'b1, sz, 1'b0, 1'b0, rs1, a);
            end else if (k < 75) begin
                op(v, 1'b0, 3'd0, 1'b0, 1'b0, 5'd1, 32'h0);
            end else if (k < 90) begin
                if (m_ranges.size() > 0 && $urandom_range(0, 1) != 0)
                    a = m_ranges[$urandom_range(0, m_ranges.size() - 1)].lo
                        + 32'($urandom_range(0, 48)) - 32'd2;
                else if (m_active && $urandom_range(0, 1) != 0)
                    a = m_start + 32'($urandom_range(0, 40));
                else
                    a = (32'($urandom_range(1, 8)) << 12) + 32'($urandom_range(0, 63));
                op(v, 1'b0, 3'd0, 1'b1, 1'b0, 5'd1, a);
            end else begin
                op(v, 1'b0, 3'd0, 1'b0, 1'b1, 5'd1, 32'h0);
            end
            clr_i  = 1'b0;
            rst_ni = 1'b1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bof_run_tracker.md
Name: bof_run_tracker

Overview:
- Detects heap buffer-overflow-shaped store runs: sequences of contiguous, non-stack stores issued to the branch/LSU functional-unit stage.
- Closes a run when it is broken or times out, and commits runs longer than a threshold into a small internal range table.
- Flags loads that hit a committed or active range, then raises a one-cycle crash request on the next JALR.
- Sits directly upstream of the branch unit's crash gating, fed from the same issue-stage operand/operator signals.

Parameters:
- VLEN, 32, address width.
- WRITE_THRESH, 32, a run is committed only if its byte count is strictly greater than this.
- DATE_MAX, 10, number of valid non-store instructions tolerated before an active run times out.
- N_RANGES, 4, range-table entries, round-robin replacement; power of two, ≥2.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset, sampled on rising clk_i.
- clr_i  in  1  software clear; same effect as reset, but only for state and outputs.
- en_crash_i  in  1  enables crash_o generation.
- valid_i  in  1  one instruction presented this cycle; all other inputs are ignored when low.
- is_store_i  in  1  instruction is SW/SH/SB.
- store_size_i  in  3  bytes stored: 1, 2 or 4. Any other value with is_store_i set is treated as a non-store.
- is_load_i  in  1  instruction is LW/LH/LB.
- is_jalr_i  in  1  instruction is JALR.
- rs1_i  in  5  base register index.
- vaddr_i  in  VLEN  effective address (imm + rs1 value).
- active_o  out  1  a run is being tracked.
- range_wr_o  out  1  one-cycle pulse: a run was committed.
- range_start_o  out  VLEN  first byte of the committed run; valid while range_wr_o is high.
- range_end_o  out  VLEN  last byte (inclusive) of the committed run; valid while range_wr_o is high.
- load_hit_o  out  1  sticky flag: the last valid load hit a range.
- crash_o  out  1  one-cycle crash request.

Behaviour:
- Reset (rst_ni=0 at a clock edge) or clr_i=1: FSM→IDLE; all table entries invalid; replacement pointer=0; count=0; date=0; all outputs 0. clr_i beats every simultaneous event.
- Tracked store: valid_i & is_store_i & legal size & rs1_i∉{2,8}. Stores based on sp/fp are ignored entirely: no state change and no date decrement.
- FSM state IDLE, tracked store:
  - go to TRACK.
  - start=vaddr_i; next=vaddr_i+size, wrapping mod 2^VLEN.
  - count=size; date=DATE_MAX.
- FSM state TRACK, tracked store with vaddr_i==next (contiguous):
  - next+=size.
  - count+=size; count is 16-bit and saturates at 0xFFFF.
  - date=DATE_MAX.
- FSM state TRACK, tracked store not contiguous:
  - close the current run.
  - restart in the same cycle from the new store: stay in TRACK with fresh start/next/count/date.
- FSM state TRACK, valid non-store instruction:
  - if date≠0, date−=1.
  - if date==0, close the run and go to IDLE.
- valid_i=0: no state change; no decrement.
- Close:
  - if count>WRITE_THRESH, write entry[ptr]={start, next−1}, set it valid, ptr=ptr+1 mod N_RANGES (oldest entry overwritten).
  - next cycle: range_wr_o=1 with range_start_o/range_end_o equal to the written values.
  - if count≤WRITE_THRESH, the run is discarded and range_wr_o stays 0.
- active_o = (state==TRACK), registered.
- Load hit check, on a valid load: hit = vaddr_i is inside any valid entry [start,end] (unsigned, inclusive), OR (TRACK and start ≤ vaddr_i < next). The check uses pre-update state of the same cycle.
- load_hit_o: registered; updated only on valid loads; holds its value otherwise.
- JALR: on valid_i & is_jalr_i & load_hit_o & en_crash_i, crash_o=1 for exactly the next cycle. load_hit_o is then cleared.
  - A JALR with en_crash_i=0 leaves load_hit_o unchanged.
- Latency: every output is registered; 1 cycle from the causing instruction.
- Wrap-around: a run crossing 0xFFFFFFFF→0 stays contiguous. A committed entry with start>end never matches a load; that is accepted behaviour.
- Reset mid-run: the run is dropped and no commit pulse is produced.

Test Plan:
- Ten SW to 0x1000,0x1004,…,0x1024 (rs1=10), then 11 valid ALU ops → after the 11th, range_wr_o=1, start=0x1000, end=0x1027; active_o=0.
- Eight SW to 0x2000..0x201C (count=32), then an SB to 0x3000 → no range_wr_o; active_o stays 1 with start=0x3000.
- Commit 0x1000–0x1027; LW 0x1010; JALR with en_crash_i=1 → load_hit_o=1 after the LW; crash_o=1 for exactly one cycle after the JALR; load_hit_o then 0.
- Same sequence with en_crash_i=0 → crash_o stays 0; load_hit_o stays 1. A following LW to 0x5000 clears it.
- Five commits at 0x1000, 0x2000, 0x3000, 0x4000, 0x5000 (N_RANGES=4), then LW 0x1004 → load_hit_o=0 because entry 0 was overwritten; LW 0x5004 → load_hit_o=1.
- SW rs1=2 interleaved in an active run, clr_i asserted together with a contiguous store, and rst_ni low mid-run → stack stores cause no change; clr_i and reset each clear all state with no range_wr_o.
